// File: rtl/conv_enc_param_if.sv
// Stream bundle for conv_enc_param: bit-serial input side and codeword output side.
// master = data source / codeword sink, slave = the encoder.
interface conv_enc_param_if #(
    parameter int N = 2
);
    logic         tail_en;
    logic         in_valid;
    logic         in_ready;
    logic         in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    modport master (
        output tail_en, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  tail_en, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_enc_param.sv
// Rate-1/N convolutional encoder with constraint length K, valid/ready streaming,
// and optional zero-tail termination of each frame.
module conv_enc_param #(
    parameter int                 K     = 5,
    parameter int                 N     = 2,
    parameter logic [N*K-1:0]     POLYS = {5'b10111, 5'b11001}
) (
    input  logic               clk,
    input  logic               rst,
    conv_enc_param_if.slave    bus
);
    localparam int            TW        = $clog2(K);
    localparam logic [TW-1:0] TCNT_LAST = TW'(K - 2);

    typedef enum logic {
        RUN  = 1'b0,
        TAIL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [K-1:0]   r_sr;
    logic [K-1:0]   w_sr_nxt;
    logic [K-1:0]   w_nxt;
    logic [TW-1:0]  r_tcnt;
    logic [TW-1:0]  w_tcnt_nxt;
    logic           r_out_valid;
    logic           r_out_last;
    logic [N-1:0]   r_out_data;
    logic           w_out_free;
    logic           w_in_xfer;
    logic           w_tail_step;
    logic           w_step;
    logic           w_bit;
    logic           w_last_nxt;

    function automatic logic [N-1:0] encode(input logic [K-1:0] window);
        logic [N-1:0] cw;
        cw = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            cw[i] = ^(POLYS[i*K +: K] & window);
        end
        return cw;
    endfunction

    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign bus.in_ready = !rst && (r_state == RUN) && w_out_free;
    assign w_in_xfer   = bus.in_valid && bus.in_ready;
    assign w_tail_step = (r_state == TAIL) && w_out_free;
    assign w_step      = w_in_xfer || w_tail_step;
    // Tail steps shift in zeros; only a real input transfer carries in_data.
    assign w_bit       = w_in_xfer && bus.in_data;
    assign w_nxt       = {w_bit, r_sr[K-1:1]};

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

    // Next state, shift register and tail counter, plus out_last of the codeword being formed
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_tcnt_nxt  = r_tcnt;
        w_last_nxt  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_in_xfer && bus.in_last && bus.tail_en) begin
                    w_state_nxt = TAIL;
                    w_sr_nxt    = w_nxt;
                    w_tcnt_nxt  = {TW{1'b0}};
                end else if (w_in_xfer && bus.in_last) begin
                    w_sr_nxt    = {K{1'b0}};
                    w_last_nxt  = 1'b1;
                end else if (w_in_xfer) begin
                    w_sr_nxt    = w_nxt;
                end else begin
                    w_sr_nxt    = r_sr;
                end
            end
            TAIL: begin
                // The final tail step would leave the last info bit in sr[0]; clear it for the next frame.
                if (w_tail_step && (r_tcnt == TCNT_LAST)) begin
                    w_state_nxt = RUN;
                    w_sr_nxt    = {K{1'b0}};
                    w_tcnt_nxt  = {TW{1'b0}};
                    w_last_nxt  = 1'b1;
                end else if (w_tail_step) begin
                    w_sr_nxt    = w_nxt;
                    w_tcnt_nxt  = r_tcnt + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    w_sr_nxt    = r_sr;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_sr_nxt    = {K{1'b0}};
                w_tcnt_nxt  = {TW{1'b0}};
            end
        endcase
    end

    // FSM state, shift register and tail counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_sr    <= {K{1'b0}};
            r_tcnt  <= {TW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Output codeword stage: load on every step, drop valid only on a bare output transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {N{1'b0}};
            r_out_last  <= 1'b0;
        end else if (w_step) begin
            r_out_valid <= 1'b1;
            r_out_data  <= encode(w_nxt);
            r_out_last  <= w_last_nxt;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
